// File: rtl/mdu_issue_pkg.sv
// Shared multiply/divide constants: opcode encodings, latencies and small decode helpers
// used by the issue logic, the MDU and the decoder.
package mdu_issue_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd8;

  localparam logic [3:0] MULT_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT  = 4'd10;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_WAIT = 1'b1
  } md_state_e;

  typedef struct packed {
    logic [MD_OP_W-1:0] op;
    logic [31:0]        rs;
    logic [31:0]        rt;
  } e_md_t;

  function automatic logic md_is_start(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_write(input logic [MD_OP_W-1:0] op);
    return (op == MD_MTHI) || (op == MD_MTLO);
  endfunction

  function automatic logic md_is_mf(input logic [MD_OP_W-1:0] op);
    return (op == MD_MFHI) || (op == MD_MFLO);
  endfunction

  function automatic logic [3:0] md_latency(input logic [MD_OP_W-1:0] op);
    return ((op == MD_DIV) || (op == MD_DIVU)) ? DIV_LAT : MULT_LAT;
  endfunction

endpackage

// File: rtl/mdu_issue_ereg.sv
// E-stage pipeline register for MD instructions: load, hold, or replace with a bubble.
module mdu_issue_ereg
  import mdu_issue_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  flush_i,
  input  logic  hold_i,
  input  logic  bubble_i,
  input  e_md_t d_i,
  output e_md_t q_o
);

  e_md_t e_d, e_q;

  // A flush wins over a hold: the excepting instruction must never reach the MDU.
  always_comb begin
    e_d = e_q;
    if (flush_i) begin
      e_d = '0;
    end else if (!hold_i) begin
      e_d = bubble_i ? '0 : d_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
    end else begin
      e_q <= e_d;
    end
  end

  assign q_o = e_q;

endmodule

// File: rtl/mdu_issue.sv
// Multiply/divide issue control: hands E-stage MD ops to the MDU, stalls dependent MD ops
// in D while the MDU is busy, and supplies mfhi/mflo results to the E result mux.
module mdu_issue
  import mdu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        d_valid,
  input  logic [3:0]  d_md_op,
  input  logic [31:0] d_rs,
  input  logic [31:0] d_rt,
  input  logic        req,
  input  logic        ext_stall,
  input  logic        mdu_busy,
  input  logic [31:0] mdu_hi,
  input  logic [31:0] mdu_lo,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_start,
  output logic        md_write,
  output logic [3:0]  md_op,
  output logic        stall_d,
  output logic        e_mf_valid,
  output logic [31:0] e_mf_data,
  output logic        busy_mismatch
);

  md_state_e  state_q;
  logic [3:0] cnt_q;
  logic       mism_q;
  e_md_t      d_md, e_q;
  logic       idle;

  assign d_md.op = d_valid ? d_md_op : MD_NONE;
  assign d_md.rs = d_rs;
  assign d_md.rt = d_rt;

  mdu_issue_ereg e_md_reg (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (req),
    .hold_i   (ext_stall),
    .bubble_i (stall_d),
    .d_i      (d_md),
    .q_o      (e_q)
  );

  assign idle       = (state_q == MD_IDLE);
  assign md_start   = md_is_start(e_q.op) & ~req & idle;
  assign md_write   = md_is_write(e_q.op) & ~req & idle;
  assign md_op      = e_q.op;
  assign md_a       = e_q.rs;
  assign md_b       = e_q.rt;
  // Only MD instructions in D care about the MDU; everything else flows past.
  assign stall_d    = d_valid & (d_md_op != MD_NONE) & (md_start | ~idle);
  assign e_mf_valid = md_is_mf(e_q.op) & idle & ~req;

  always_comb begin
    e_mf_data = '0;
    if (e_q.op == MD_MFHI) begin
      e_mf_data = mdu_hi;
    end else if (e_q.op == MD_MFLO) begin
      e_mf_data = mdu_lo;
    end
  end

  // The MDU cannot be aborted, so req never shortens WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (md_start && !ext_stall) begin
            state_q <= MD_WAIT;
            cnt_q   <= md_latency(e_q.op);
          end
        end
        MD_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= MD_IDLE;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mism_q <= 1'b0;
    end else if (mdu_busy != (state_q == MD_WAIT)) begin
      mism_q <= 1'b1;
    end
  end

  assign busy_mismatch = mism_q;

endmodule

// File: tb/tb_mdu_issue.sv
// Directed bench for mdu_issue with a small behavioural MDU providing busy/HI/LO.
module tb_mdu_issue;
  import mdu_issue_pkg::*;

  logic        clk, reset, d_valid, req, ext_stall, mdu_busy;
  logic [3:0]  d_md_op, md_op;
  logic [31:0] d_rs, d_rt, mdu_hi, mdu_lo, md_a, md_b, e_mf_data;
  logic        md_start, md_write, stall_d, e_mf_valid, busy_mismatch;
  logic        bad_busy;

  int n_tests = 0;
  int n_fail  = 0;

  mdu_issue dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_md_op(d_md_op),
    .d_rs(d_rs), .d_rt(d_rt), .req(req), .ext_stall(ext_stall),
    .mdu_busy(mdu_busy), .mdu_hi(mdu_hi), .mdu_lo(mdu_lo),
    .md_a(md_a), .md_b(md_b), .md_start(md_start), .md_write(md_write),
    .md_op(md_op), .stall_d(stall_d), .e_mf_valid(e_mf_valid),
    .e_mf_data(e_mf_data), .busy_mismatch(busy_mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural MDU: starts when the issue logic actually issues, busy for the op latency.
  logic       mb_q;
  logic [3:0] mc_q;
  logic [31:0] hi_q, lo_q;
  always @(posedge clk) begin
    if (reset) begin
      mb_q <= 1'b0; mc_q <= '0; hi_q <= '0; lo_q <= '0;
    end else begin
      if (mb_q) begin
        mc_q <= mc_q - 4'd1;
        if (mc_q == 4'd1) mb_q <= 1'b0;
      end else if (md_start && !ext_stall) begin
        mb_q <= 1'b1;
        mc_q <= (md_op <= 4'd2) ? 4'd5 : 4'd10;
      end
      if (md_start && !ext_stall) begin
        case (md_op)
          4'd1: {hi_q, lo_q} <= longint'($signed(md_a)) * longint'($signed(md_b));
          4'd2: {hi_q, lo_q} <= {32'd0, md_a} * {32'd0, md_b};
          4'd3: if (md_b != 0) begin lo_q <= $signed(md_a) / $signed(md_b); hi_q <= $signed(md_a) % $signed(md_b); end
          4'd4: if (md_b != 0) begin lo_q <= md_a / md_b; hi_q <= md_a % md_b; end
          default: ;
        endcase
      end
      if (md_write && md_op == 4'd5) hi_q <= md_a;
      if (md_write && md_op == 4'd6) lo_q <= md_a;
    end
  end
  assign mdu_busy = mb_q | bad_busy;
  assign mdu_hi   = hi_q;
  assign mdu_lo   = lo_q;

  typedef struct {
    logic        dv;
    logic [3:0]  op;
    logic [31:0] rs, rt;
    logic        x_stall, x_start, x_write, x_mfv;
    logic [31:0] x_mfd, x_a;
    logic [3:0]  x_op;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic dv, input logic [3:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic rq, input logic xs);
    d_valid = dv; d_md_op = op; d_rs = rs; d_rt = rt; req = rq; ext_stall = xs;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, stall_d}, 32'd0);
    chk({tag, "_start"}, {31'd0, md_start}, 32'd0);
    chk({tag, "_write"}, {31'd0, md_write}, 32'd0);
    chk({tag, "_mfv"}, {31'd0, e_mf_valid}, 32'd0);
    chk({tag, "_mfd"}, e_mf_data, 32'd0);
    chk({tag, "_a"}, md_a, 32'd0);
    chk({tag, "_b"}, md_b, 32'd0);
    chk({tag, "_op"}, {28'd0, md_op}, 32'd0);
    chk({tag, "_mism"}, {31'd0, busy_mismatch}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ns, nst;
    // mult 3*-2 with mflo queued behind it, then mthi/mfhi back-to-back, then a non-MD op
    tbl[0]  = '{1'b1, 4'd1, 32'd3, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[1]  = '{1'b1, 4'd8, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd3, 4'd1};
    for (int i = 2; i <= 6; i++)
      tbl[i] = '{1'b1, 4'd8, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[7]  = '{1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[8]  = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFA, 32'd0, 4'd8};
    tbl[9]  = '{1'b1, 4'd5, 32'h12345678, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[10] = '{1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'h12345678, 4'd5};
    tbl[11] = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'd0, 4'd7};
    tbl[12] = '{1'b1, 4'd0, 32'hAAAA, 32'h5555, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0};
    tbl[13] = '{1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'hAAAA, 4'd0};

    bad_busy = 1'b0;
    reset = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick; tick;
    reset = 1'b0;
    #1 chk_zero("reset");

    foreach (tbl[i]) begin
      drive(tbl[i].dv, tbl[i].op, tbl[i].rs, tbl[i].rt, 1'b0, 1'b0);
      #1;
      chk($sformatf("row%0d_stall", i), {31'd0, stall_d}, {31'd0, tbl[i].x_stall});
      chk($sformatf("row%0d_start", i), {31'd0, md_start}, {31'd0, tbl[i].x_start});
      chk($sformatf("row%0d_write", i), {31'd0, md_write}, {31'd0, tbl[i].x_write});
      chk($sformatf("row%0d_mfv", i), {31'd0, e_mf_valid}, {31'd0, tbl[i].x_mfv});
      chk($sformatf("row%0d_mfd", i), e_mf_data, tbl[i].x_mfd);
      chk($sformatf("row%0d_a", i), md_a, tbl[i].x_a);
      chk($sformatf("row%0d_op", i), {28'd0, md_op}, {28'd0, tbl[i].x_op});
      tick;
    end
    chk("table_mism", {31'd0, busy_mismatch}, 32'd0);

    // divu 7/2 then mfhi, mflo
    drive(1'b1, 4'd4, 32'd7, 32'd2, 1'b0, 1'b0); tick;
    drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall_d) break;
      n++;
      tick;
    end
    chk("divu_stall_cycles", n, 32'd11);
    tick;
    drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0); #1;
    chk("divu_mfhi_valid", {31'd0, e_mf_valid}, 32'd1);
    chk("divu_mfhi_data", e_mf_data, 32'd1);
    tick;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0); #1;
    chk("divu_mflo_data", e_mf_data, 32'd3);
    tick;

    // mult flushed by req in E
    drive(1'b1, 4'd1, 32'd5, 32'd5, 1'b0, 1'b0); tick;
    drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b1, 1'b0); #1;
    chk("req_start", {31'd0, md_start}, 32'd0);
    chk("req_stall", {31'd0, stall_d}, 32'd0);
    tick;
    drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, 1'b0); #1;
    chk("req_after_stall", {31'd0, stall_d}, 32'd0);
    chk("req_after_start", {31'd0, md_start}, 32'd0);
    tick;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0); #1;
    chk("req_mfv_masked", {31'd0, e_mf_valid}, 32'd0);
    req = 1'b0; #1;
    chk("req_mfv", {31'd0, e_mf_valid}, 32'd1);
    chk("req_prior_hi", e_mf_data, 32'd1);
    chk("req_mism", {31'd0, busy_mismatch}, 32'd0);
    tick;

    // div held by ext_stall for 3 cycles
    drive(1'b1, 4'd3, 32'd100, 32'd7, 1'b0, 1'b0); tick;
    ns = 0; nst = 0;
    for (int i = 0; i < 60; i++) begin
      drive(1'b1, 4'd7, 32'd0, 32'd0, 1'b0, (i < 3));
      #1;
      if (!stall_d) break;
      ns++;
      if (md_start) nst++;
      tick;
    end
    chk("xs_start_cycles", nst, 32'd4);
    chk("xs_stall_cycles", ns, 32'd14);
    tick;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0); #1;
    chk("xs_mfhi_data", e_mf_data, 32'd2);
    chk("xs_mism", {31'd0, busy_mismatch}, 32'd0);
    tick;

    // reset in WAIT with cnt=4
    drive(1'b1, 4'd1, 32'd2, 32'd3, 1'b0, 1'b0); tick;
    drive(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0); tick; tick;
    #1 chk("rst_wait_stall", {31'd0, stall_d}, 32'd1);
    reset = 1'b1; tick;
    #1 chk_zero("rst_wait");
    reset = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick;
    #1 chk("rst_after_mism", {31'd0, busy_mismatch}, 32'd0);

    // busy disagreement sets the sticky flag until reset
    bad_busy = 1'b1; tick;
    bad_busy = 1'b0; #1;
    chk("mism_set", {31'd0, busy_mismatch}, 32'd1);
    tick; #1;
    chk("mism_sticky", {31'd0, busy_mismatch}, 32'd1);
    reset = 1'b1; tick;
    reset = 1'b0; #1;
    chk("mism_clear", {31'd0, busy_mismatch}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_issue.md
MDU_ISSUE -- requirements
Module: mdu_issue

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock; reset is reset, synchronous, active-high; clock clk.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port d_valid, input, 1, D-stage holds a valid instruction.
REQ-004 SHALL have port d_md_op, input, 4, D-stage MD opcode: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo.
REQ-005 SHALL have ports d_rs, d_rt, input, 32 each, forwarded D-stage operands.
REQ-006 SHALL have port req, input, 1, exception/interrupt flush of E stage.
REQ-007 SHALL have port ext_stall, input, 1, stall requested by other hazard logic.
REQ-008 SHALL have ports mdu_busy, input, 1, and mdu_hi, mdu_lo, input, 32 each, all from the downstream MDU.
REQ-009 SHALL have ports md_a, md_b, output, 32 each, MDU operands from the E register.
REQ-010 SHALL have ports md_start, md_write, output, 1 each; md_op, output, 4.
REQ-011 SHALL have port stall_d, output, 1, freeze D and inject a bubble into E.
REQ-012 SHALL have ports e_mf_valid, output, 1, and e_mf_data, output, 32, mfhi/mflo result for the E-stage result mux.
REQ-013 SHALL have port busy_mismatch, output, 1, sticky checker flag.

Function
REQ-014 E register (op, rs, rt) SHALL load D values on each edge when stall_d=0 and ext_stall=0; SHALL load a bubble (op 0) when stall_d=1 and ext_stall=0; SHALL hold when ext_stall=1; an op with d_valid=0 SHALL load as 0.
REQ-015 md_start SHALL equal (E op in 1..4) & ~req & (state==IDLE); md_write SHALL equal (E op in 5..6) & ~req & (state==IDLE); md_op SHALL equal E op; md_a=E rs, md_b=E rt.
REQ-016 States: IDLE, WAIT. IDLE->WAIT on an edge where md_start=1 and ext_stall=0, loading cnt=5 (ops 1,2) or 10 (ops 3,4).
REQ-017 In WAIT, cnt SHALL decrement by 1 per edge; WAIT->IDLE on the edge where cnt==1.
REQ-018 stall_d SHALL equal d_valid & (d_md_op!=0) & (md_start | state==WAIT); non-MD instructions SHALL never be stalled by this block.
REQ-019 With ext_stall=1 in the issue cycle, md_start SHALL stay asserted and no transition SHALL occur until ext_stall drops.
REQ-020 req=1 SHALL suppress md_start/md_write, SHALL flush E to bubble on that edge regardless of ext_stall, and SHALL NOT abort WAIT (the MDU does not abort).
REQ-021 e_mf_valid SHALL equal (E op in 7..8) & (state==IDLE) & ~req; e_mf_data SHALL be mdu_hi for op 7, mdu_lo for op 8, else 0.
REQ-022 busy_mismatch SHALL set, and stay set until reset, on any edge where mdu_busy != (state==WAIT).
REQ-023 Back-to-back: an MD op in D behind mult in E SHALL see stall_d high for exactly 6 cycles (1 issue + 5 WAIT), 11 for div.

Reset
REQ-024 reset SHALL clear E register to bubble, state to IDLE, cnt to 0, busy_mismatch to 0; consequently all outputs SHALL be 0 in the first cycle after reset.
REQ-025 reset mid-WAIT SHALL return to IDLE immediately; the MDU is reset by the same signal.

Structure
REQ-026 MD opcode encodings (0..8) and latencies 5 and 10 SHALL be constants in the shared CPU package, also used by the MDU and decoder.
REQ-027 No sub-module is required; the E register may be a separate pipeline-register instance, e_md_reg.

Verification
REQ-028 mult rs=3, rt=-2 issued, mflo behind it -> stall_d high 6 cycles, then e_mf_data=0xFFFFFFFA, busy_mismatch=0.
REQ-029 divu 7/2 followed by mfhi -> stall_d 11 cycles; e_mf_data=1; mflo next -> 3.
REQ-030 mult in E with req=1 -> md_start=0, state stays IDLE, following mfhi not stalled, returns prior HI.
REQ-031 mthi 0x12345678 then mfhi back-to-back -> no stall, e_mf_data=0x12345678.
REQ-032 div issued with ext_stall=1 for 3 cycles -> md_start held 4 cycles, WAIT entered once, 10 cycles.
REQ-033 reset asserted in WAIT cnt=4 -> next cycle state IDLE, stall_d=0, all outputs 0.
